// File: rtl/link_tx_gearbox.sv
// link_tx_gearbox: serialises ARQ link words into LSB-first PHY beats with abort and statistics.
// Ports: clk/rst (sync, active-high); tx_link_* / tx_prio offer a word, tx_accept / tx_reject answer it;
// link_up / phy_ready come from the PHY; phy_* carry beats with sof/eof/prio framing and an abort pulse;
// words_sent / words_rejected are saturating counters.
package fatmeshy_pkg;
  localparam int LINK_WORD_SIZE = 20;
endpackage

module link_tx_gearbox #(
  parameter int WORD_WIDTH = fatmeshy_pkg::LINK_WORD_SIZE,
  parameter int LANE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_link_valid,
  input  logic [WORD_WIDTH-1:0] tx_link_data,
  input  logic                  tx_prio,
  output logic                  tx_accept,
  output logic                  tx_reject,
  input  logic                  link_up,
  input  logic                  phy_ready,
  output logic                  phy_valid,
  output logic [LANE_WIDTH-1:0] phy_data,
  output logic                  phy_sof,
  output logic                  phy_eof,
  output logic                  phy_prio,
  output logic                  phy_abort,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic [CNT_WIDTH-1:0]  words_rejected
);
  localparam int BEATS = (WORD_WIDTH + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int BW = $clog2(BEATS);
  localparam int SW = BEATS * LANE_WIDTH;
  typedef enum logic {IDLE, SEND} state_e;
  state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d, rej_q, rej_d;
  logic prio_q, prio_d, abort_q, abort_d, send, last, on;
  always_comb begin
    send = state_q == SEND;
    last = send & phy_ready & (beat_q == BW'(BEATS - 1));
    tx_accept = !rst & tx_link_valid & link_up & (!send | last);
    tx_reject = !rst & tx_link_valid & !link_up;
    // a last beat consumed while the link drops still completes; only a truncated word aborts
    state_d = tx_accept ? SEND : (last | !link_up) ? IDLE : state_q;
    beat_d = tx_accept ? '0 : (send & phy_ready) ? beat_q + 1'b1 : beat_q;
    // the current beat always sits in the low lane, so shift right as beats are consumed
    shift_d = tx_accept ? SW'(tx_link_data) : (send & phy_ready) ? shift_q >> LANE_WIDTH : shift_q;
    prio_d = tx_accept ? tx_prio : prio_q;
    abort_d = send & !link_up & !last;
    sent_d = sent_q + CNT_WIDTH'(last & ~&sent_q);
    rej_d = rej_q + CNT_WIDTH'(tx_reject & ~&rej_q);
    // outputs are gated by rst so they read zero for the whole reset cycle
    on = send & !rst;
    phy_valid = on;
    phy_data = on ? shift_q[LANE_WIDTH-1:0] : '0;
    phy_sof = on & (beat_q == '0);
    phy_eof = on & (beat_q == BW'(BEATS - 1));
    phy_prio = on & prio_q;
    phy_abort = abort_q & !rst;
    words_sent = sent_q;
    words_rejected = rej_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      shift_q <= '0;
      prio_q <= 1'b0;
      abort_q <= 1'b0;
      sent_q <= '0;
      rej_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      shift_q <= shift_d;
      prio_q <= prio_d;
      abort_q <= abort_d;
      sent_q <= sent_d;
      rej_q <= rej_d;
    end
  end
endmodule

// File: tb/tb_link_tx_gearbox.sv
// tb_link_tx_gearbox: randomized scoreboard bench for link_tx_gearbox against a word-level model.
module tb_link_tx_gearbox;
  localparam int NB = 3;
  logic clk = 1'b0;
  logic rst, v, prio, lu, pr;
  logic [19:0] data;
  logic acc_o, rej_o, pv_o, sof_o, eof_o, pp_o, ab_o;
  logic [7:0] pd_o;
  logic [15:0] ws_o, wr_o;
  logic s_acc, s_rej, s_pv, s_sof, s_eof, s_pp, s_ab;
  logic [7:0] s_pd;
  logic [1:0] s_ws, s_wr;

  always #5 clk = ~clk;

  link_tx_gearbox dut (
    .clk(clk), .rst(rst), .tx_link_valid(v), .tx_link_data(data), .tx_prio(prio),
    .tx_accept(acc_o), .tx_reject(rej_o), .link_up(lu), .phy_ready(pr),
    .phy_valid(pv_o), .phy_data(pd_o), .phy_sof(sof_o), .phy_eof(eof_o), .phy_prio(pp_o),
    .phy_abort(ab_o), .words_sent(ws_o), .words_rejected(wr_o)
  );

  link_tx_gearbox #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .tx_link_valid(v), .tx_link_data(data), .tx_prio(prio),
    .tx_accept(s_acc), .tx_reject(s_rej), .link_up(lu), .phy_ready(pr),
    .phy_valid(s_pv), .phy_data(s_pd), .phy_sof(s_sof), .phy_eof(s_eof), .phy_prio(s_pp),
    .phy_abort(s_ab), .words_sent(s_ws), .words_rejected(s_wr)
  );

  typedef struct {bit acc; bit rej; bit valid; bit abort; bit rst; bit pr; bit known; int sent; int rejd;} cyc_t;
  typedef struct {logic [19:0] d; bit p;} word_t;
  cyc_t cq[$];
  word_t wq[$];
  int checks = 0, failures = 0, idx = 0;
  bit done = 0;
  bit inflight = 0, abort_pend = 0, known = 0, last_acc, last_rej;
  int rem = 0, sent = 0, rejd = 0;
  bit cur_v = 0, cur_p = 0;
  logic [19:0] cur_d = '0;

  function automatic int sat3(int x);
    return x > 3 ? 3 : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit iv, input bit ip, input bit ilu, input bit ipr, input logic [19:0] id);
    cyc_t c;
    bit last, acc, rej;
    rst = r; v = iv; prio = ip; lu = ilu; pr = ipr; data = id;
    c.rst = r; c.pr = ipr; c.known = known; c.sent = sent; c.rejd = rejd;
    c.abort = abort_pend & !r;
    c.valid = inflight & !r;
    acc = 0; rej = 0;
    if (r) begin
      inflight = 0; abort_pend = 0; sent = 0; rejd = 0; known = 1;
    end else begin
      last = inflight && rem == 1 && ipr;
      acc = iv && ilu && (!inflight || last);
      rej = iv && !ilu;
      abort_pend = inflight && !ilu && !last;
      sent += int'(last);
      rejd += int'(rej);
      if (acc) begin
        inflight = 1; rem = NB;
        wq.push_back('{id, ip});
      end else if (last || abort_pend) inflight = 0;
      else if (inflight && ipr) rem--;
    end
    c.acc = acc; c.rej = rej;
    cq.push_back(c);
    last_acc = acc; last_rej = rej;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int pv, input int plu, input int ppr, input int prst);
    for (int i = 0; i < n; i++) begin
      if (!cur_v && ($urandom % 100) < pv) begin
        cur_v = 1; cur_d = 20'($urandom); cur_p = 1'($urandom);
      end
      cycle(($urandom % 100) < prst, cur_v, cur_p, ($urandom % 100) < plu, ($urandom % 100) < ppr, cur_d);
      if (last_acc || last_rej) cur_v = 0;
    end
  endtask

  always @(negedge clk) begin
    cyc_t c;
    word_t w;
    logic [23:0] x;
    if (cq.size() != 0) begin
      c = cq.pop_front();
      check("tx_accept", acc_o, c.acc);
      check("tx_reject", rej_o, c.rej);
      check("phy_valid", pv_o, c.valid);
      check("phy_abort", ab_o, c.abort);
      if (c.known) begin
        check("words_sent", ws_o, c.sent);
        check("words_rejected", wr_o, c.rejd);
        check("sat_words_sent", s_ws, sat3(c.sent));
        check("sat_words_rejected", s_wr, sat3(c.rejd));
      end
      if (c.rst) begin
        wq.delete(); idx = 0;
      end else if (c.abort) begin
        if (wq.size() != 0) void'(wq.pop_front());
        idx = 0;
      end
      if (c.valid) begin
        if (wq.size() == 0) check("beat_word_present", 0, 1);
        else begin
          w = wq[0];
          x = {4'b0, w.d};
          check("phy_data", pd_o, x[8*idx +: 8]);
          check("phy_sof", sof_o, idx == 0);
          check("phy_eof", eof_o, idx == NB - 1);
          check("phy_prio", pp_o, w.p);
          if (c.pr) begin
            idx++;
            if (idx == NB) begin
              idx = 0;
              void'(wq.pop_front());
            end
          end
        end
      end else check("idle_outputs", {pd_o, sof_o, eof_o, pp_o}, 0);
    end else if (!done) check("cycle_item_present", 0, 1);
  end

  initial begin
    rst = 1; v = 0; prio = 0; lu = 0; pr = 0; data = '0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, '0);
    cycle(1, 1, 0, 1, 1, 20'hFFFFF);
    cycle(0, 1, 1, 1, 1, 20'hABCDE);
    repeat (3) cycle(0, 0, 0, 1, 1, '0);
    run(10, 100, 100, 100, 0);
    run(30, 100, 100, 30, 0);
    run(5, 100, 0, 100, 0);
    cycle(0, 1, 0, 1, 1, 20'h12345);
    cycle(0, 0, 0, 1, 1, '0);
    cycle(0, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, 1, '0);
    cycle(0, 1, 1, 1, 1, 20'h5A5A5);
    cycle(0, 0, 0, 1, 1, '0);
    cycle(1, 1, 1, 1, 1, 20'h0F0F0);
    cycle(0, 0, 0, 1, 1, '0);
    run(3000, 70, 92, 75, 1);
    run(8, 100, 0, 100, 0);
    done = 1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/link_tx_gearbox.md
LINK_TX_GEARBOX -- requirements
Module: link_tx_gearbox

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default fatmeshy_pkg::LINK_WORD_SIZE, width of one link word from the ARQ stage.
REQ-002 SHALL have parameter LANE_WIDTH, default 8, width of one PHY beat; BEATS = ceil(WORD_WIDTH/LANE_WIDTH), BEATS >= 2.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tx_link_valid  input  1  ARQ offers a link word; held until tx_accept or tx_reject.
REQ-007 tx_link_data  input  WORD_WIDTH  link word {flit, seq}, stable while tx_link_valid=1.
REQ-008 tx_prio  input  1  word is priority (retransmit/ack); qualified by tx_link_valid.
REQ-009 tx_accept  output  1  word captured this cycle.
REQ-010 tx_reject  output  1  word refused this cycle; ARQ keeps it for retry.
REQ-011 link_up  input  1  PHY link trained and usable.
REQ-012 phy_ready  input  1  PHY consumes the current beat this cycle.
REQ-013 phy_valid  output  1  phy_data holds a valid beat.
REQ-014 phy_data  output  LANE_WIDTH  current beat.
REQ-015 phy_sof / phy_eof  output  1 each  first / last beat of a word.
REQ-016 phy_prio  output  1  copy of captured tx_prio, valid on every beat of the word.
REQ-017 phy_abort  output  1  one-cycle pulse: in-flight word truncated.
REQ-018 words_sent / words_rejected  output  CNT_WIDTH each  saturating statistics counters.

Function
REQ-019 SHALL implement states IDLE and SEND with beat counter beat_cnt of width clog2(BEATS).
REQ-020 Capture condition: tx_link_valid & link_up & (state==IDLE | (state==SEND & beat_cnt==BEATS-1 & phy_ready)); tx_accept SHALL equal it combinationally.
REQ-021 tx_reject SHALL equal tx_link_valid & !link_up combinationally; tx_accept and tx_reject SHALL never both be 1.
REQ-022 With link_up=1 and the gearbox busy, neither accept nor reject SHALL assert (ARQ stalls).
REQ-023 On capture: shift register <= tx_link_data zero-padded to BEATS*LANE_WIDTH, prio reg <= tx_prio, beat_cnt <= 0, state <= SEND.
REQ-024 In SEND: phy_valid=1, phy_data = bits [beat_cnt*LANE_WIDTH +: LANE_WIDTH] (LSB beat first), phy_sof=(beat_cnt==0), phy_eof=(beat_cnt==BEATS-1).
REQ-025 Beat advances only when phy_ready=1; with phy_ready=0 all phy_* outputs SHALL hold unchanged.
REQ-026 Last beat consumed: words_sent increments; next state SEND (beat 0 of new word) if capture in same cycle, else IDLE — back-to-back words SHALL have zero idle cycles.
REQ-027 In IDLE: phy_valid=phy_sof=phy_eof=phy_prio=0, phy_data=0.
REQ-028 link_up=0 while in SEND SHALL: next state IDLE, phy_abort=1 for exactly that next cycle, phy_valid=0 in that cycle, words_sent unchanged; the last beat consumed in the same cycle link_up falls SHALL still count as sent and SHALL NOT abort.
REQ-029 Each cycle with tx_reject=1 SHALL increment words_rejected by 1.
REQ-030 Both counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-031 Latency: captured word's first beat SHALL appear on phy_data the cycle after tx_accept.

Reset
REQ-032 rst=1 SHALL force state IDLE, beat_cnt 0, shift/prio regs 0, both counters 0, all phy_* outputs 0; tx_accept=tx_reject=0 during reset.
REQ-033 rst asserted mid-SEND SHALL drop the word silently without phy_abort; tx_link_valid is ignored while rst=1.

Verification (WORD_WIDTH=20, LANE_WIDTH=8, BEATS=3)
REQ-034 link_up=1, phy_ready=1, offer 0xABCDE prio=1 -> accept cycle 0; beats 0xDE(sof), 0xBC, 0x0A(eof) cycles 1-3, phy_prio=1; words_sent=1.
REQ-035 Two words offered continuously, phy_ready=1 -> second accepted on the eof cycle of the first; 6 consecutive valid beats, no gap; words_sent=2.
REQ-036 phy_ready=0 for 4 cycles on beat 1 -> phy_data/sof/eof stable; resumes at beat 1; no accept of a pending word until eof consumed.
REQ-037 link_up=0, tx_link_valid=1 for 3 cycles -> tx_reject=1 each cycle, tx_accept=0, words_rejected=3, phy_valid=0.
REQ-038 link_up drops during beat 1 -> next cycle phy_abort=1, phy_valid=0, state IDLE, words_sent unchanged; rst pulse mid-SEND -> all outputs 0, no phy_abort.
REQ-039 Force words_rejected to 0xFFFE, reject 3 words -> counter holds 0xFFFF.
